// File: rtl/operand_entry_pkg.sv
// operand_entry_pkg: shared operand width and entry FSM state encoding
package operand_entry_pkg;
  localparam int OPERAND_W = 8;
  typedef enum logic [1:0] {
    GET_A = 2'b00,
    GET_B = 2'b01,
    DONE  = 2'b10
  } entry_state_t;
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: synchronize, debounce and rising-edge detect one raw button
module button_debouncer #(
  parameter int DB_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise_pulse
);
  localparam int CW = $clog2(DB_CYCLES);
  logic sync1_q, sync2_q, level_q, level_d, prev_q, pulse_q, pulse_d, flip;
  logic [CW-1:0] cnt_q, cnt_d;
  // count consecutive disagreeing cycles; flip the level on the last one
  always_comb begin
    flip = (sync2_q != level_q) && (cnt_q == CW'(DB_CYCLES - 1));
    cnt_d = (sync2_q == level_q || flip) ? '0 : cnt_q + 1'b1;
    level_d = level_q ^ flip;
    pulse_d = level_q & ~prev_q;
  end
  // synchronizer, debounce state and registered rise pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end
  assign level = level_q;
  assign rise_pulse = pulse_q;
endmodule

// File: rtl/operand_entry.sv
// operand_entry: capture operands A then B from switches on debounced load presses
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int DB_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OPERAND_W-1:0] sw,
  input  logic                 btn_load,
  input  logic                 btn_clear,
  output logic [OPERAND_W-1:0] a,
  output logic [OPERAND_W-1:0] b,
  output logic                 valid,
  output logic [1:0]           state_led
);
  entry_state_t state_q, state_d;
  logic [OPERAND_W-1:0] a_q, a_d, b_q, b_d;
  logic valid_q, valid_d, ld, clr;
  button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_load (
    .clk(clk), .rst(rst), .btn_raw(btn_load), .level(), .rise_pulse(ld)
  );
  button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_clear (
    .clk(clk), .rst(rst), .btn_raw(btn_clear), .level(), .rise_pulse(clr)
  );
  // next state and operands; clear beats load, the unused encoding recovers to GET_A
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    valid_d = valid_q;
    if (clr) begin
      state_d = GET_A;
      a_d = '0;
      b_d = '0;
      valid_d = 1'b0;
    end else if (state_q == GET_A) begin
      state_d = ld ? GET_B : GET_A;
      a_d = ld ? sw : a_q;
    end else if (state_q == GET_B) begin
      state_d = ld ? DONE : GET_B;
      b_d = ld ? sw : b_q;
      valid_d = ld | valid_q;
    end else if (state_q == DONE) begin
      state_d = ld ? GET_B : DONE;
      a_d = ld ? sw : a_q;
      b_d = ld ? '0 : b_q;
      valid_d = ~ld & valid_q;
    end else begin
      state_d = GET_A;
    end
  end
  // state and operand registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GET_A;
      a_q <= '0;
      b_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      valid_q <= valid_d;
    end
  end
  assign a = a_q;
  assign b = b_q;
  assign valid = valid_q;
  assign state_led = state_q;
endmodule

// File: tb/tb_operand_entry.sv
// tb_operand_entry: directed stimulus, behavioural model and per-cycle compare
module tb_operand_entry;
  localparam int DB = 4;
  logic clk = 1'b0, rst = 1'b1, btn_load = 1'b0, btn_clear = 1'b0;
  logic [7:0] sw = 8'h00, a, b;
  logic valid;
  logic [1:0] state_led;
  int checks = 0, failures = 0;
  bit armed = 1'b0;
  bit [DB:0] h [2];
  bit lvl [2], plvl [2], pul [2];
  logic [7:0] ma, mb;
  logic mv;
  logic [1:0] ms;
  operand_entry #(.DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_load(btn_load), .btn_clear(btn_clear),
    .a(a), .b(b), .valid(valid), .state_led(state_led)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        h[k] = '0; lvl[k] = 0; plvl[k] = 0; pul[k] = 0;
      end
      ma = 0; mb = 0; mv = 0; ms = 0; armed = 1'b1;
    end else begin
      if (pul[1]) begin
        ma = 0; mb = 0; mv = 0; ms = 0;
      end else if (pul[0]) begin
        if (ms == 0) begin ma = sw; ms = 1; end
        else if (ms == 1) begin mb = sw; mv = 1; ms = 2; end
        else begin ma = sw; mb = 0; mv = 0; ms = 1; end
      end
      for (int k = 0; k < 2; k++) begin
        bit nl;
        nl = (lvl[k] ? (h[k][DB:1] == '0) : (&h[k][DB:1])) ? ~lvl[k] : lvl[k];
        pul[k] = lvl[k] & ~plvl[k];
        plvl[k] = lvl[k];
        lvl[k] = nl;
      end
      h[0] = {h[0][DB-1:0], btn_load};
      h[1] = {h[1][DB-1:0], btn_clear};
    end
  end
  always @(negedge clk) if (armed) begin
    chk("model_a", a, ma);
    chk("model_b", b, mb);
    chk("model_valid", {7'b0, valid}, {7'b0, mv});
    chk("model_state", {6'b0, state_led}, {6'b0, ms});
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic outs(input string name, input logic [7:0] ea, input logic [7:0] eb, input logic ev, input logic [1:0] es);
    chk({name, "_a"}, a, ea);
    chk({name, "_b"}, b, eb);
    chk({name, "_valid"}, {7'b0, valid}, {7'b0, ev});
    chk({name, "_state"}, {6'b0, state_led}, {6'b0, es});
  endtask
  initial begin
    sw = 8'h5A; btn_load = 1'b1;
    tick(4);
    outs("in_reset", 8'h00, 8'h00, 1'b0, 2'b00);
    rst = 1'b0;
    tick(7);
    outs("reset_pre7", 8'h00, 8'h00, 1'b0, 2'b00);
    tick(1);
    outs("reset_edge7", 8'h5A, 8'h00, 1'b0, 2'b01);
    btn_load = 1'b0; tick(12);
    btn_clear = 1'b1; tick(10); btn_clear = 1'b0; tick(12);
    outs("clear", 8'h00, 8'h00, 1'b0, 2'b00);
    sw = 8'h3C; btn_load = 1'b1;
    tick(7); chk("a_pre7", a, 8'h00);
    tick(1); outs("cap_a", 8'h3C, 8'h00, 1'b0, 2'b01);
    tick(2); btn_load = 1'b0; tick(12);
    sw = 8'hA5; btn_load = 1'b1;
    tick(7); chk("b_pre7", b, 8'h00);
    tick(1); outs("cap_b", 8'h3C, 8'hA5, 1'b1, 2'b10);
    tick(2); btn_load = 1'b0; tick(12);
    foreach (h[i]) begin end
    btn_load = 1'b1; tick(1); btn_load = 1'b0; tick(1);
    btn_load = 1'b1; tick(1); btn_load = 1'b0; tick(12);
    outs("bounce", 8'h3C, 8'hA5, 1'b1, 2'b10);
    btn_load = 1'b1; tick(3); btn_load = 1'b0; tick(12);
    outs("glitch3", 8'h3C, 8'hA5, 1'b1, 2'b10);
    sw = 8'hFF; btn_load = 1'b1; tick(10); btn_load = 1'b0; tick(12);
    outs("reentry", 8'hFF, 8'h00, 1'b0, 2'b01);
    btn_load = 1'b1; btn_clear = 1'b1; tick(10);
    btn_load = 1'b0; btn_clear = 1'b0; tick(12);
    outs("simul", 8'h00, 8'h00, 1'b0, 2'b00);
    sw = 8'h11; btn_load = 1'b1; tick(8);
    outs("held_cap", 8'h11, 8'h00, 1'b0, 2'b01);
    sw = 8'h22; tick(42);
    outs("held_once", 8'h11, 8'h00, 1'b0, 2'b01);
    btn_load = 1'b0; tick(10);
    btn_load = 1'b1;
    tick(7); chk("held_next_pre7", b, 8'h00);
    tick(1); outs("held_next", 8'h11, 8'h22, 1'b1, 2'b10);
    btn_load = 1'b0; tick(12);
    btn_load = 1'b1; tick(3);
    rst = 1'b1; tick(1); rst = 1'b0;
    tick(7); outs("midrst_pre7", 8'h00, 8'h00, 1'b0, 2'b00);
    tick(1); outs("midrst_cap", 8'h22, 8'h00, 1'b0, 2'b01);
    btn_load = 1'b0; tick(12);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/operand_entry.md
# operand_entry

Debounced switch-and-button operand entry for the 8-bit adder display path. It captures operand A, then operand B, from the slide switches on successive presses of a load button. It then presents both operands with a valid flag to the ripple-carry adder, whose sum feeds the four-digit seven-segment driver. A clear button returns the block to operand-A entry.

## Interface
- `DB_CYCLES`, default 100000: consecutive cycles a synchronized button level must differ from its debounced level before the debounced level flips (1 ms at 100 MHz); minimum 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sw`  in  8  slide switches, operand value; treated as quasi-static, sampled directly (no synchronizer).
- `btn_load`  in  1  raw asynchronous load button, active-high.
- `btn_clear`  in  1  raw asynchronous clear button, active-high.
- `a`  out  8  captured operand A, registered.
- `b`  out  8  captured operand B, registered.
- `valid`  out  1  high while both operands are captured (state DONE).
- `state_led`  out  2  current state encoding, for board LEDs.

## Operation
- Each button passes through its own debouncer, then through a rising-edge detector:
  - 2-flop synchronizer.
  - Counter of width `$clog2(DB_CYCLES)`: clears whenever the synchronized level equals the debounced level; otherwise it increments. On the DB_CYCLES-th consecutive differing cycle, the debounced level toggles and the counter clears.
  - One-cycle registered pulse on the rising edge of the debounced level.
  - Release and bounce never generate pulses.
- FSM states (`state_led` encoding):
  - GET_A (2'b00)
  - GET_B (2'b01)
  - DONE (2'b10)
  - 2'b11 is unused and recovers to GET_A on the next edge.
- Transitions on the debounced load pulse `ld`:
  - GET_A: `a <= sw`, go to GET_B.
  - GET_B: `b <= sw`, `valid <= 1`, go to DONE.
  - DONE: `a <= sw`, `b <= 0`, `valid <= 0`, go to GET_B. This starts a new entry and keeps the new A.
- Clear pulse `clr` in any state: `a <= 0`, `b <= 0`, `valid <= 0`, go to GET_A.
- `clr` and `ld` in the same cycle: `clr` wins and `ld` is discarded.
- With no pulse, all outputs hold.
- No arithmetic is performed here. Operands are unsigned 8-bit and passed through unchanged.

## Timing
- Reset values:
  - `a` = 0, `b` = 0, `valid` = 0, state GET_A, `state_led` = 2'b00.
  - Synchronizer flops, debounced levels, counters, and pulse registers all reset to 0.
  - A button already held high at reset release is therefore seen as a press after debounce.
- Debounce latency (edge 0 = first edge sampling the raw input high, input held steady):
  - Debounced level rises at edge DB_CYCLES+1.
  - Pulse is high for exactly the one cycle following edge DB_CYCLES+2.
- Capture latency:
  - `a`, `b`, `valid`, and state update on the edge that samples the pulse, i.e. edge DB_CYCLES+3.
  - Captured value is `sw` at that edge.
- Bounce: any return of the synchronized level to the debounced level before DB_CYCLES cycles restarts the count from 0. No pulse is produced.
- Release debounces with the same latency and produces no pulse. A new press is recognized only after the release has been debounced.
- Reset mid-debounce discards the partial count. Reset mid-entry discards captured operands.
- `valid` rises and falls only on clock edges, together with `a`/`b`, so the adder never sees a half-updated operand pair with `valid` = 1.

## Structure
- Shared package `operand_entry_pkg`:
  - State typedef `entry_state_t` with the 2-bit encodings above.
  - Localparam `OPERAND_W` = 8.
- Sub-module `button_debouncer`, parameterized by `DB_CYCLES`:
  - Ports `clk`, `rst`, `btn_raw`, `level`, `rise_pulse`.
  - Instantiated twice, once for load and once for clear.
- The top level holds the FSM and operand registers only.

## Test plan
All scenarios use DB_CYCLES = 4.
- **Reset:** assert `rst` with `btn_load` held high. Outputs are 0 and state is 2'b00 throughout reset. After release, the load press is recognized at edge 7 and `a` = `sw`.
- **Normal entry:** `sw` = 8'h3C, press load for 10 cycles, release; `sw` = 8'hA5, press again. Result: `a` = 8'h3C, `b` = 8'hA5, `valid` = 1, `state_led` = 2'b10. Each capture occurs exactly 7 edges after its press.
- **Bounce rejection:** raw load toggles 1,0,1,0 on successive cycles, then stays 0. No pulse occurs and `a`, `b`, and state are unchanged. A 3-cycle-high glitch is also rejected.
- **Re-entry from DONE:** from DONE with `a` = 8'h3C and `b` = 8'hA5, set `sw` = 8'hFF and press load. Result: `a` = 8'hFF, `b` = 0, `valid` = 0, state GET_B.
- **Simultaneous press:** load and clear pressed on the same cycle while in GET_B. Result: state GET_A, `a` = `b` = 0, `valid` = 0. No capture occurs.
- **Held button:** hold load for 50 cycles. Exactly one pulse and one capture occur. The next capture happens only after release plus 4 cycles, followed by a new press.
